// File: rtl/sap_1_controller_sequencer_if.sv
// Signal bundle between the instruction register / front panel and the
// SAP-1 control matrix, as seen by the controller-sequencer.
interface sap_1_controller_sequencer_if;
  logic [3:0] opcode;
  logic       MAN;
  logic       STEP;
  logic [6:1] ring_counter;
  logic       LDA;
  logic       ADD;
  logic       SUB;
  logic       OUT;
  logic       HLT;
  logic       HALTED;

  modport master (
    output opcode, MAN, STEP,
    input  ring_counter, LDA, ADD, SUB, OUT, HLT, HALTED
  );

  modport slave (
    input  opcode, MAN, STEP,
    output ring_counter, LDA, ADD, SUB, OUT, HLT, HALTED
  );
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer front end: one-hot T1-T6 ring, opcode decode,
// HLT freeze and edge-detected manual single-step.
module sap_1_controller_sequencer (
  input logic                           CLK,
  input logic                           CLR,
  sap_1_controller_sequencer_if.slave   bus
);

  typedef enum logic [5:0] {
    T_NONE = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } tstate_e;

  tstate_e ring_q, ring_d;
  tstate_e ring_next;
  logic    halted_q, halted_d;
  logic    step_q, step_d;
  logic    adv;
  logic    halt_cond;
  logic    exec_phase;
  logic [4:0] dec;

  assign adv       = ~bus.MAN | (bus.MAN & bus.STEP & ~step_q);
  assign halt_cond = adv & ring_q[3] & (bus.opcode == 4'b1111);

  // Any state outside the six legal T-states recovers to T1 on rotation.
  always_comb begin
    ring_next = T1;
    case (ring_q)
      T1:      ring_next = T2;
      T2:      ring_next = T3;
      T3:      ring_next = T4;
      T4:      ring_next = T5;
      T5:      ring_next = T6;
      T6:      ring_next = T1;
      default: ring_next = T1;
    endcase
  end

  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    step_d   = bus.STEP;
    if (!halted_q && adv) begin
      if (halt_cond) begin
        ring_d   = T_NONE;
        halted_d = 1'b1;
      end else begin
        ring_d = ring_next;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
      step_q   <= step_d;
    end
  end

  // Opcode is only trusted once fetch has finished (T4..T6).
  assign exec_phase = (ring_q[3] | ring_q[4] | ring_q[5]) & ~halted_q;

  always_comb begin
    dec = '0;
    case (bus.opcode)
      4'b0000: dec = 5'b10000;
      4'b0001: dec = 5'b01000;
      4'b0010: dec = 5'b00100;
      4'b1110: dec = 5'b00010;
      4'b1111: dec = 5'b00001;
      default: dec = '0;
    endcase
  end

  assign bus.ring_counter = ring_q;
  assign bus.HALTED       = halted_q;
  assign bus.LDA          = dec[4] & exec_phase;
  assign bus.ADD          = dec[3] & exec_phase;
  assign bus.SUB          = dec[2] & exec_phase;
  assign bus.OUT          = dec[1] & exec_phase;
  assign bus.HLT          = dec[0] & exec_phase;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Scoreboard bench for sap_1_controller_sequencer: directed scenarios plus
// random traffic against a T-state-number reference model.
module tb_sap_1_controller_sequencer;

  logic CLK;
  logic CLR;

  sap_1_controller_sequencer_if bus ();

  sap_1_controller_sequencer dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [6:1] ring;
    logic       halted;
    logic [4:0] dec;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests  = 0;
  int failed = 0;
  int cyc_n  = 0;

  // Reference model: T-state as a number 1..6 (0 = none), plus halt flag.
  int m_t      = 0;
  bit m_halt   = 0;
  bit m_pstep  = 0;
  bit m_valid  = 0;

  function automatic logic [4:0] decode_ref(input logic [3:0] op);
    case (op)
      4'd0:    return 5'b10000;
      4'd1:    return 5'b01000;
      4'd2:    return 5'b00100;
      4'd14:   return 5'b00010;
      4'd15:   return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic cycle(input bit clr, input bit man, input bit step, input logic [3:0] op);
    exp_t e;
    bit adv;
    CLR        = clr;
    bus.MAN    = man;
    bus.STEP   = step;
    bus.opcode = op;
    if (m_valid) begin
      e.ring   = (m_t == 0) ? 6'b000000 : 6'(1 << (m_t - 1));
      e.halted = m_halt;
      e.dec    = (!m_halt && m_t >= 4) ? decode_ref(op) : 5'b00000;
      e.cyc    = cyc_n;
      exp_q.push_back(e);
    end
    @(posedge CLK);
    if (clr) begin
      m_t = 1; m_halt = 0; m_pstep = 0; m_valid = 1;
    end else begin
      adv = !man || (step && !m_pstep);
      if (!m_halt && adv) begin
        if (m_t == 4 && op == 4'hF) begin
          m_halt = 1; m_t = 0;
        end else begin
          m_t = (m_t >= 1 && m_t <= 5) ? m_t + 1 : 1;
        end
      end
      m_pstep = step;
    end
    cyc_n++;
    #1;
  endtask

  task automatic reset2();
    cycle(1, 0, 0, 4'h0);
    cycle(1, 0, 0, 4'h0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    logic [4:0] dec_a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        dec_a = {bus.LDA, bus.ADD, bus.SUB, bus.OUT, bus.HLT};
        tests++;
        if (bus.ring_counter !== e.ring) begin
          failed++;
          $display("FAIL ring cyc=%0d got=%b exp=%b", e.cyc, bus.ring_counter, e.ring);
        end
        tests++;
        if (bus.HALTED !== e.halted) begin
          failed++;
          $display("FAIL halted cyc=%0d got=%b exp=%b", e.cyc, bus.HALTED, e.halted);
        end
        tests++;
        if (dec_a !== e.dec) begin
          failed++;
          $display("FAIL decode cyc=%0d got=%b exp=%b", e.cyc, dec_a, e.dec);
        end
      end
    end
  end

  initial begin
    CLR = 1'b0; bus.MAN = 1'b0; bus.STEP = 1'b0; bus.opcode = 4'h0;
    @(posedge CLK); #1;

    // Reset then free-run ADD for a full instruction and wrap.
    reset2();
    repeat (7) cycle(0, 0, 0, 4'h1);

    // Decode sweep: every opcode across T1..T6.
    for (int op = 0; op < 16; op++) begin
      reset2();
      repeat (6) cycle(0, 0, 0, 4'(op));
    end

    // Halt at T4, then activity while frozen, then clear.
    reset2();
    repeat (3) cycle(0, 0, 0, 4'h3);
    cycle(0, 0, 0, 4'hF);
    repeat (20) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    cycle(1, 0, 0, 4'h0);
    cycle(0, 1, 0, 4'h0);

    // Single-step: idle, held high, release and press again.
    reset2();
    repeat (5) cycle(0, 1, 0, 4'h1);
    repeat (4) cycle(0, 1, 1, 4'h1);
    cycle(0, 1, 0, 4'h1);
    cycle(0, 1, 1, 4'h1);
    repeat (6) begin
      cycle(0, 1, 0, 4'h2);
      cycle(0, 1, 1, 4'h2);
    end
    cycle(0, 1, 0, 4'h2);

    // Clear at T5 in free-run.
    reset2();
    repeat (4) cycle(0, 0, 0, 4'h0);
    cycle(1, 0, 0, 4'h0);
    cycle(0, 0, 0, 4'h0);

    // STEP held high across a MAN 0->1 switch.
    reset2();
    repeat (2) cycle(0, 0, 1, 4'h5);
    repeat (3) cycle(0, 1, 1, 4'h5);
    cycle(0, 1, 0, 4'h5);
    cycle(0, 1, 1, 4'h5);
    cycle(0, 1, 1, 4'h5);

    // Random traffic; HLT is made rarer so the ring keeps moving.
    reset2();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)), op);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sap_1_controller_sequencer.md
# sap_1_controller_sequencer

Front end of the SAP-1 controller-sequencer: generates the six-state one-hot ring counter (T1–T6) and the decoded instruction lines (LDA, ADD, SUB, OUT, HLT) consumed by the SAP-1 control matrix. It decodes the opcode nibble from the instruction register, freezes the machine on HLT, and supports a manual single-step mode for front-panel debugging. It sits between the instruction register and the control matrix.

## Interface
- No parameters; widths are fixed by the SAP-1 architecture.
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  reset, synchronous, active-high.
- opcode  input  4  upper nibble of the instruction register.
- MAN  input  1  1 = manual single-step mode; 0 = free-run.
- STEP  input  1  manual step request, level signal from a debounced switch.
- ring_counter  output  6  one-hot T-state, bit 1 = T1 through bit 6 = T6.
- LDA, ADD, SUB, OUT, HLT  output  1 each  decoded instruction lines.
- HALTED  output  1  machine stopped by HLT.

## Operation
- Opcode map:
  - 0000 = LDA
  - 0001 = ADD
  - 0010 = SUB
  - 1110 = OUT
  - 1111 = HLT
  - All other codes are NOPs: no decoded line is asserted and the ring cycles normally.
- Decoded lines are combinational: decode(opcode) AND (ring_counter[4] | ring_counter[5] | ring_counter[6]) AND ~HALTED.
  - They are forced to 0 during T1–T3, because the IR is still fetching and the opcode is stale.
- Ring counter registers:
  - Advance enable: adv = ~MAN, or (MAN & STEP & ~step_q), where step_q is a 1-cycle registered copy of STEP.
  - On a clock edge with adv=1, not halted, and no halt condition: ring rotates left (T1→T2→…→T6→T1).
  - On a clock edge with adv=0: ring holds.
- Halt condition: adv=1 AND ring_counter[4] AND opcode==1111.
  - On that edge, HALTED is set and ring_counter becomes 000000.
  - With an all-zero ring, every control-matrix output is inactive.
  - While HALTED=1, ring and HALTED hold regardless of MAN/STEP/opcode. Only CLR exits.
- Integrity: if the ring is ever non-one-hot while HALTED=0 (including 000000), the next advancing edge loads 000001 (T1).
- Mode switching: MAN may change on any cycle.
  - It takes effect on the same edge; no partial steps occur.
  - step_q is always updated, so holding STEP high while switching MAN 0→1 does not produce a step.

## Timing
- Reset values (edge with CLR=1 dominates everything):
  - ring_counter=000001
  - HALTED=0
  - step_q=0
  - Decoded lines therefore read 0.
- Free-run: one T-state per clock; an instruction occupies exactly 6 cycles.
- Step mode: exactly one advance per STEP 0→1 transition.
  - The advance lands on the first edge where STEP=1 is sampled with step_q=0.
  - STEP held high gives exactly one step.
  - STEP toggling every cycle gives one step per 2 cycles.
- HLT latency: the HLT line is visible combinationally during T4. HALTED=1 and ring=000000 appear after the T4 edge.
- CLR mid-instruction (any T-state, halted or not): the next state is T1 and HALTED=0, with no residual step pending.
- Decoded-line changes follow opcode within the same cycle (no added latency) during T4–T6.

## Test plan
- Reset/free-run:
  - Stimulus: CLR=1 for 2 cycles, then MAN=0, opcode=0001.
  - Required: ring reads 000001, 000010, 000100, 001000, 010000, 100000, 000001.
  - ADD=1 only while ring ∈ {001000, 010000, 100000}.
- Decode sweep:
  - Stimulus: all 16 opcodes at T5.
  - Required: exactly one line high for 0000/0001/0010/1110/1111; all lines 0 for the other 11 codes; all lines 0 at T1–T3 for every code.
- Halt:
  - Stimulus: opcode=1111 at T4.
  - Required: HLT=1 during T4; next cycle HALTED=1 and ring=000000; unchanged after 20 further cycles with opcode toggling and MAN/STEP activity.
  - Then CLR=1 gives ring=000001, HALTED=0.
- Single-step:
  - Stimulus: MAN=1, STEP held 0 for 5 cycles.
  - Required: ring stays 000001.
  - Stimulus: STEP high for 4 cycles. Required: ring becomes 000010 once, with no further advance.
  - Stimulus: STEP 0 then 1. Required: ring 000100.
- Reset mid-operation and mode switch:
  - Stimulus: CLR at T5 in free-run. Required: next ring=000001.
  - Stimulus: STEP=1 held while switching MAN 0→1. Required: no advance until STEP falls and rises again.
